// File: rtl/idt_cfg_loader.sv
// Serial configuration loader for an IDT clock synthesizer: shifts a 24-bit
// word MSB-first on idt_sclk/idt_data, waits a gap, then pulses idt_strobe.
module idt_cfg_loader #(
    parameter int CLK_DIV       = 1,
    parameter int GAP_CYCLES    = 14,
    parameter int STROBE_CYCLES = 2
) (
    input  logic        osc_clk,
    input  logic        osc_reset,
    input  logic        cfg_valid,
    input  logic [23:0] cfg_data,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, STROBE} state_t;

    localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

    state_t      r_state, w_state_nx;
    logic [23:0] r_shift, w_shift_nx;
    logic [4:0]  r_bit, w_bit_nx;
    logic [7:0]  r_phase, w_phase_nx;
    logic        r_half, w_half_nx;
    logic        r_sclk, w_sclk_nx;
    logic        r_data, w_data_nx;
    logic        r_strobe, w_strobe_nx;
    logic        r_done, w_done_nx;

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_phase  <= '0;
            r_half   <= 1'b0;
            r_sclk   <= 1'b0;
            r_data   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_bit    <= w_bit_nx;
            r_phase  <= w_phase_nx;
            r_half   <= w_half_nx;
            r_sclk   <= w_sclk_nx;
            r_data   <= w_data_nx;
            r_strobe <= w_strobe_nx;
            r_done   <= w_done_nx;
        end
    end

    // Outputs are computed one cycle ahead so every idt_* pin comes from a flop.
    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bit_nx    = r_bit;
        w_phase_nx  = r_phase;
        w_half_nx   = r_half;
        w_sclk_nx   = r_sclk;
        w_data_nx   = r_data;
        w_strobe_nx = r_strobe;
        w_done_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_state_nx = SHIFT;
                    w_data_nx  = cfg_data[23];
                    w_shift_nx = {cfg_data[22:0], 1'b0};
                    w_sclk_nx  = 1'b0;
                    w_bit_nx   = '0;
                    w_phase_nx = '0;
                    w_half_nx  = 1'b0;
                end
            end
            SHIFT: begin
                if (r_phase == DIV_LAST) begin
                    w_phase_nx = '0;
                    if (!r_half) begin
                        w_half_nx = 1'b1;
                        w_sclk_nx = 1'b1;
                    end else if (r_bit == 5'd23) begin
                        w_half_nx = 1'b0;
                        w_sclk_nx = 1'b0;
                        w_data_nx = 1'b0;
                        w_bit_nx  = '0;
                        if (GAP_CYCLES == 0) begin
                            w_state_nx  = STROBE;
                            w_strobe_nx = 1'b1;
                        end else begin
                            w_state_nx = GAP;
                        end
                    end else begin
                        w_bit_nx   = r_bit + 5'd1;
                        w_half_nx  = 1'b0;
                        w_sclk_nx  = 1'b0;
                        w_data_nx  = r_shift[23];
                        w_shift_nx = {r_shift[22:0], 1'b0};
                    end
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end
            GAP: begin
                if (r_phase == GAP_LAST) begin
                    w_phase_nx  = '0;
                    w_state_nx  = STROBE;
                    w_strobe_nx = 1'b1;
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end
            STROBE: begin
                if (r_phase == STROBE_LAST) begin
                    w_phase_nx  = '0;
                    w_state_nx  = IDLE;
                    w_strobe_nx = 1'b0;
                    w_done_nx   = 1'b1;
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign cfg_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign idt_sclk   = r_sclk;
    assign idt_data   = r_data;
    assign idt_strobe = r_strobe;

endmodule
